// File: rtl/peripheral_uart_pkg.sv
// Shared UART constants: receive-FIFO error-flag layout, timeout length and
// the trigger-level helper.
package peripheral_uart_pkg;

  localparam int UART_FIFO_ERR_W       = 3;
  localparam int UART_FIFO_ERR_BI      = 2;
  localparam int UART_FIFO_ERR_PE      = 1;
  localparam int UART_FIFO_ERR_FE      = 0;
  localparam int UART_RX_TIMEOUT_CHARS = 4;

  typedef enum logic [1:0] {
    TRIG_ONE     = 2'b00,
    TRIG_QUARTER = 2'b01,
    TRIG_HALF    = 2'b10,
    TRIG_NEAR    = 2'b11
  } uart_trig_sel_e;

  // Receive-FIFO occupancy level at which trig_o asserts for a given select.
  function automatic int unsigned uart_trig_level(input logic [1:0] sel,
                                                  input int unsigned depth);
    int unsigned lvl;
    case (uart_trig_sel_e'(sel))
      TRIG_ONE:     lvl = 1;
      TRIG_QUARTER: lvl = depth / 4;
      TRIG_HALF:    lvl = depth / 2;
      default:      lvl = depth - 2;
    endcase
    return lvl;
  endfunction

endpackage

// File: rtl/peripheral_uart_fifo_mem.sv
// Receive-FIFO storage: DEPTH x WIDTH array, synchronous write, asynchronous read.
module peripheral_uart_fifo_mem
  import peripheral_uart_pkg::*;
#(
  parameter int WIDTH = 11,
  parameter int DEPTH = 16,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk_i,
  input  logic             wr_en_i,
  input  logic [PTR_W-1:0] wr_addr_i,
  input  logic [WIDTH-1:0] wr_data_i,
  input  logic [PTR_W-1:0] rd_addr_i,
  output logic [WIDTH-1:0] rd_data_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (wr_en_i) mem_q[wr_addr_i] <= wr_data_i;
  end

  assign rd_data_o = mem_q[rd_addr_i];

endmodule

// File: rtl/peripheral_uart_rx_fifo_param.sv
// Parametrised UART receive FIFO with per-entry error flags, trigger, overrun,
// error-in-FIFO and (optional, macro UART_RX_TIMEOUT_EN) character timeout.
module peripheral_uart_rx_fifo_param
  import peripheral_uart_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int ERR_W  = UART_FIFO_ERR_W,
  parameter int DEPTH  = 16,
  parameter int PTR_W  = $clog2(DEPTH),
  parameter int CNT_W  = PTR_W + 1
) (
  input  logic                    wb_clk_i,
  input  logic                    wb_rst_i,
  input  logic                    push_i,
  input  logic [DATA_W+ERR_W-1:0] data_i,
  input  logic                    pop_i,
  input  logic                    fifo_clr_i,
  input  logic                    clr_status_i,
  input  logic [1:0]              trig_sel_i,
  input  logic                    char_tick_i,
  output logic [DATA_W+ERR_W-1:0] data_o,
  output logic [CNT_W-1:0]        count_o,
  output logic                    empty_o,
  output logic                    full_o,
  output logic                    overrun_o,
  output logic                    err_o,
  output logic                    trig_o,
  output logic                    timeout_o
);

  localparam int ENTRY_W = DATA_W + ERR_W;
  localparam logic [CNT_W-1:0] LVL_ONE     = CNT_W'(uart_trig_level(2'b00, DEPTH));
  localparam logic [CNT_W-1:0] LVL_QUARTER = CNT_W'(uart_trig_level(2'b01, DEPTH));
  localparam logic [CNT_W-1:0] LVL_HALF    = CNT_W'(uart_trig_level(2'b10, DEPTH));
  localparam logic [CNT_W-1:0] LVL_NEAR    = CNT_W'(uart_trig_level(2'b11, DEPTH));

  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d, err_cnt_q, err_cnt_d;
  logic               overrun_q, overrun_d, trig_q, trig_d;
  logic [ENTRY_W-1:0] head;
  logic [CNT_W-1:0]   trig_lvl;
  logic               empty, full, wr_en, rd_en, push_err, pop_err;

  assign empty = (count_q == '0);
  assign full  = (count_q == CNT_W'(DEPTH));

  // A full FIFO still accepts a push when the head is popped in the same cycle.
  assign wr_en = wb_rst_i && push_i && !fifo_clr_i && (!full || pop_i);
  assign rd_en = pop_i && !fifo_clr_i && !empty;

  assign push_err = wr_en && (|data_i[ENTRY_W-1:DATA_W]);
  assign pop_err  = rd_en && (|head[ENTRY_W-1:DATA_W]);

  peripheral_uart_fifo_mem #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH),
    .PTR_W (PTR_W)
  ) u_mem (
    .clk_i     (wb_clk_i),
    .wr_en_i   (wr_en),
    .wr_addr_i (wr_ptr_q),
    .wr_data_i (data_i),
    .rd_addr_i (rd_ptr_q),
    .rd_data_o (head)
  );

  always_comb begin
    case (trig_sel_i)
      2'b00:   trig_lvl = LVL_ONE;
      2'b01:   trig_lvl = LVL_QUARTER;
      2'b10:   trig_lvl = LVL_HALF;
      default: trig_lvl = LVL_NEAR;
    endcase
  end

  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    err_cnt_d = err_cnt_q;
    overrun_d = overrun_q;
    if (fifo_clr_i) begin
      wr_ptr_d  = '0;
      rd_ptr_d  = '0;
      count_d   = '0;
      err_cnt_d = '0;
      overrun_d = 1'b0;
    end else begin
      if (wr_en) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (rd_en) rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({wr_en, rd_en})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
      case ({push_err, pop_err})
        2'b10:   err_cnt_d = err_cnt_q + CNT_W'(1);
        2'b01:   err_cnt_d = err_cnt_q - CNT_W'(1);
        default: err_cnt_d = err_cnt_q;
      endcase
      // A dropped push outranks a simultaneous status-read clear.
      if (push_i && !pop_i && full) overrun_d = 1'b1;
      else if (clr_status_i)        overrun_d = 1'b0;
    end
    trig_d = (count_d >= trig_lvl);
  end

  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_i) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      err_cnt_q <= '0;
      overrun_q <= 1'b0;
      trig_q    <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      err_cnt_q <= err_cnt_d;
      overrun_q <= overrun_d;
      trig_q    <= trig_d;
    end
  end

`ifdef UART_RX_TIMEOUT_EN
  localparam logic [2:0] TO_MAX = 3'(UART_RX_TIMEOUT_CHARS);
  logic [2:0] to_cnt_q, to_cnt_d;

  always_comb begin
    to_cnt_d = to_cnt_q;
    if (push_i || pop_i || fifo_clr_i || empty) to_cnt_d = '0;
    else if (char_tick_i && (to_cnt_q != TO_MAX)) to_cnt_d = to_cnt_q + 3'd1;
  end

  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_i) to_cnt_q <= '0;
    else           to_cnt_q <= to_cnt_d;
  end

  assign timeout_o = (to_cnt_q == TO_MAX) && !empty;
`else
  logic unused_char_tick;
  assign unused_char_tick = char_tick_i;
  assign timeout_o        = 1'b0;
`endif

  assign data_o    = empty ? '0 : head;
  assign count_o   = count_q;
  assign empty_o   = empty;
  assign full_o    = full;
  assign overrun_o = overrun_q;
  assign err_o     = (err_cnt_q != '0);
  assign trig_o    = trig_q;

endmodule

// File: tb/tb_peripheral_uart_rx_fifo_param.sv
// Directed self-checking bench for peripheral_uart_rx_fifo_param (DEPTH=16);
// timeout checks follow UART_RX_TIMEOUT_EN.
module tb_peripheral_uart_rx_fifo_param;

  localparam int DATA_W = 8;
  localparam int ERR_W  = 3;
  localparam int DEPTH  = 16;
  localparam int CNT_W  = 5;

  logic                    wb_clk_i = 1'b0;
  logic                    wb_rst_i;
  logic                    push_i, pop_i, fifo_clr_i, clr_status_i, char_tick_i;
  logic [DATA_W+ERR_W-1:0] data_i;
  logic [1:0]              trig_sel_i;
  logic [DATA_W+ERR_W-1:0] data_o;
  logic [CNT_W-1:0]        count_o;
  logic                    empty_o, full_o, overrun_o, err_o, trig_o, timeout_o;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 wb_clk_i = ~wb_clk_i;

  peripheral_uart_rx_fifo_param #(
    .DATA_W (DATA_W),
    .ERR_W  (ERR_W),
    .DEPTH  (DEPTH)
  ) dut (
    .wb_clk_i     (wb_clk_i),
    .wb_rst_i     (wb_rst_i),
    .push_i       (push_i),
    .data_i       (data_i),
    .pop_i        (pop_i),
    .fifo_clr_i   (fifo_clr_i),
    .clr_status_i (clr_status_i),
    .trig_sel_i   (trig_sel_i),
    .char_tick_i  (char_tick_i),
    .data_o       (data_o),
    .count_o      (count_o),
    .empty_o      (empty_o),
    .full_o       (full_o),
    .overrun_o    (overrun_o),
    .err_o        (err_o),
    .trig_o       (trig_o),
    .timeout_o    (timeout_o)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge wb_clk_i);
    #1;
  endtask

  task automatic push(input logic [DATA_W+ERR_W-1:0] d);
    push_i = 1'b1;
    data_i = d;
    tick();
    push_i = 1'b0;
    data_i = '0;
  endtask

  task automatic pop();
    pop_i = 1'b1;
    tick();
    pop_i = 1'b0;
  endtask

  task automatic clear_fifo();
    fifo_clr_i = 1'b1;
    tick();
    fifo_clr_i = 1'b0;
  endtask

  initial begin
    wb_rst_i = 1'b0; push_i = 1'b0; pop_i = 1'b0; fifo_clr_i = 1'b0;
    clr_status_i = 1'b0; char_tick_i = 1'b0; data_i = '0; trig_sel_i = 2'b00;

    // Reset
    repeat (3) tick();
    check("rst_empty",   32'(empty_o),   32'd1);
    check("rst_count",   32'(count_o),   32'd0);
    check("rst_data",    32'(data_o),    32'd0);
    check("rst_full",    32'(full_o),    32'd0);
    check("rst_overrun", 32'(overrun_o), 32'd0);
    check("rst_err",     32'(err_o),     32'd0);
    check("rst_trig",    32'(trig_o),    32'd0);
    check("rst_timeout", 32'(timeout_o), 32'd0);
    wb_rst_i = 1'b1;
    tick();

    // Basic push / pop ordering
    push(11'h041); push(11'h042); push(11'h043);
    check("b_count", 32'(count_o), 32'd3);
    check("b_trig1", 32'(trig_o),  32'd1);
    check("b_head0", 32'(data_o),  32'h041); pop();
    check("b_head1", 32'(data_o),  32'h042); pop();
    check("b_head2", 32'(data_o),  32'h043); pop();
    check("b_empty", 32'(empty_o), 32'd1);
    check("b_data0", 32'(data_o),  32'd0);
    pop();
    check("b_pop_empty_count", 32'(count_o), 32'd0);

    // Fill, overrun, status clear, push&pop at full
    for (int i = 0; i < 16; i++) push(11'(8'h10 + i));
    check("f_full",    32'(full_o),    32'd1);
    check("f_count",   32'(count_o),   32'd16);
    check("f_no_ovr",  32'(overrun_o), 32'd0);
    push(11'h0EE);
    check("f_overrun", 32'(overrun_o), 32'd1);
    check("f_count17", 32'(count_o),   32'd16);
    check("f_head",    32'(data_o),    32'h010);
    clr_status_i = 1'b1; tick(); clr_status_i = 1'b0;
    check("f_ovr_clr", 32'(overrun_o), 32'd0);
    push_i = 1'b1; pop_i = 1'b1; data_i = 11'h099; tick();
    push_i = 1'b0; pop_i = 1'b0; data_i = '0;
    check("f_pp_count", 32'(count_o),   32'd16);
    check("f_pp_ovr",   32'(overrun_o), 32'd0);
    check("f_pp_head",  32'(data_o),    32'h011);
    push_i = 1'b1; clr_status_i = 1'b1; data_i = 11'h0AA; tick();
    push_i = 1'b0; clr_status_i = 1'b0; data_i = '0;
    check("f_set_wins", 32'(overrun_o), 32'd1);
    for (int i = 0; i < 15; i++) pop();
    check("f_tail", 32'(data_o), 32'h099);
    clear_fifo();
    check("f_clr_empty", 32'(empty_o),   32'd1);
    check("f_clr_ovr",   32'(overrun_o), 32'd0);

    // Trigger levels
    trig_sel_i = 2'b10;
    for (int i = 0; i < 7; i++) push(11'(i));
    check("t_half7", 32'(trig_o), 32'd0);
    push(11'h007);
    check("t_half8", 32'(trig_o), 32'd1);
    trig_sel_i = 2'b11;
    tick();
    check("t_near8", 32'(trig_o), 32'd0);
    for (int i = 0; i < 5; i++) push(11'(i));
    check("t_near13", 32'(trig_o), 32'd0);
    push(11'h00D);
    check("t_near14", 32'(trig_o), 32'd1);
    trig_sel_i = 2'b01;
    clear_fifo();
    check("t_clr", 32'(trig_o), 32'd0);
    for (int i = 0; i < 4; i++) push(11'(i));
    check("t_quarter4", 32'(trig_o), 32'd1);
    clear_fifo();
    trig_sel_i = 2'b00;

    // Error tracking
    push({3'b010, 8'h55});
    push(11'h000);
    check("e_err",  32'(err_o),  32'd1);
    check("e_head", 32'(data_o), 32'h255);
    pop();
    check("e_err_pop", 32'(err_o), 32'd0);
    push({3'b100, 8'h00});
    check("e_err_bi", 32'(err_o), 32'd1);
    clear_fifo();
    check("e_clr_err",   32'(err_o),   32'd0);
    check("e_clr_count", 32'(count_o), 32'd0);
    check("e_clr_data",  32'(data_o),  32'd0);

    // Character timeout
    push(11'h061);
    char_tick_i = 1'b1;
    repeat (3) tick();
    check("to_3ticks", 32'(timeout_o), 32'd0);
    tick();
`ifdef UART_RX_TIMEOUT_EN
    check("to_4ticks", 32'(timeout_o), 32'd1);
    tick();
    check("to_sat",    32'(timeout_o), 32'd1);
`else
    check("to_4ticks", 32'(timeout_o), 32'd0);
`endif
    char_tick_i = 1'b0;
    pop();
    check("to_pop", 32'(timeout_o), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
